hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core. It owns every stall, freeze and flush decision and sits beside forwarding_unit in the ID/EX boundary logic.
- Handles three cases:
  - load-use hazards, with a configurable stall length;
  - taken-branch flushes;
  - data-memory wait-state freezes, backed by a timeout watchdog.
- Drives the write-enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_wait_counter.sv | 30 +++
 rtl/hazard_controller.sv | 162 ++++++++++++++++
 tb/tb_hazard_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller state encoding, forward-select
// codes used by forwarding_unit, and the register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/hazard_wait_counter.sv
// Loadable counter that saturates at both ends; serves as the load-use stall
// counter (load/decrement) and as the memory-wait watchdog (increment/clear).
module hazard_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall / freeze / flush sequencing for the 5-stage pipeline.
// Defining HAZARD_PERF_CNT_EN adds the stall_cycles/flush_events/wait_cycles counters.
module hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ID_Rs1,
    input  logic [REG_IDX_W-1:0] ID_Rs2,
    input  logic                 ID_UsesRs1,
    input  logic                 ID_UsesRs2,
    input  logic [REG_IDX_W-1:0] EX_Rd,
    input  logic                 EX_MemRead,
    input  logic                 EX_BranchTaken,
    input  logic                 MEM_Req,
    input  logic                 MEM_Ready,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Write,
    output logic                 ID_EX_Flush,
    output logic                 EX_MEM_Write,
    output logic                 MEM_WB_Flush,
    output logic [1:0]           ctrl_state,
    output logic                 mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events,
    output logic [31:0]          wait_cycles
`endif
);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYC - 1);
    localparam logic [9:0] TIMEOUT_M1   = 10'(MEM_TIMEOUT - 1);

    ctrl_state_t state, next_state, saved_state, eff_state;
    logic        mem_stall, load_use, save_en;
    logic        stall_load, stall_dec, stall_clear;
    logic [2:0]  stall_cnt;
    logic [9:0]  wait_cnt;

    assign mem_stall = MEM_Req & ~MEM_Ready;
    assign load_use  = EX_MemRead & (EX_Rd != '0) &
                       ((ID_UsesRs1 & (EX_Rd == ID_Rs1)) | (ID_UsesRs2 & (EX_Rd == ID_Rs2)));

    // On release from a freeze, behave exactly as the interrupted state would.
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;

    hazard_wait_counter #(.W(3)) u_stall_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (stall_clear),
        .load     (stall_load),
        .load_val (STALL_RELOAD),
        .inc      (1'b0),
        .dec      (stall_dec),
        .count    (stall_cnt)
    );

    hazard_wait_counter #(.W(10)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (~mem_stall),
        .load     (1'b0),
        .load_val (10'd0),
        .inc      (mem_stall),
        .dec      (1'b0),
        .count    (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            saved_state <= RUN;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (save_en) begin
                saved_state <= state;
            end
            if (mem_stall && (wait_cnt >= TIMEOUT_M1)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        next_state   = RUN;
        save_en      = 1'b0;
        stall_load   = 1'b0;
        stall_dec    = 1'b0;
        stall_clear  = 1'b0;
        if (reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to MEM; stall counter holds so a pending stall resumes intact.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
            next_state   = MEM_WAIT;
            save_en      = (state != MEM_WAIT);
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            stall_clear = 1'b1;
        end else if (eff_state == LOAD_STALL) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            stall_dec   = 1'b1;
            next_state  = (stall_cnt <= 3'd1) ? RUN : LOAD_STALL;
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            stall_load  = 1'b1;
            next_state  = (LOAD_STALL_CYC == 1) ? RUN : LOAD_STALL;
        end
    end

    assign ctrl_state = reset ? 2'd0 : state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            wait_cycles  <= '0;
        end else begin
            if (!PCWrite && !mem_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (IF_ID_Flush) begin
                flush_events <= flush_events + 32'd1;
            end
            if (mem_stall) begin
                wait_cycles <= wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (1-cycle and 3-cycle load stall)
// share stimulus and are checked every cycle against a rule-level model.
module tb_hazard_controller;

  localparam int T   = 8;
  localparam int C_A = 1;
  localparam int C_B = 3;

  // Control vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}
  localparam logic [6:0] V_RESET  = 7'b0010101;
  localparam logic [6:0] V_FREEZE = 7'b0000001;
  localparam logic [6:0] V_BRANCH = 7'b1111110;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_IDLE   = 7'b1101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses1, uses2, memread, branch, mreq, mready;

  logic       pcw [2], ifw [2], ifl [2], idw [2], idf [2], emw [2], mwf [2], tmo [2];
  logic [1:0] cst [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc [2], fe [2], wc [2];
  logic [31:0] m_stall [2], m_flush [2], m_wait [2];
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Rule-level model: remaining bubbles, whether the previous cycle froze, run length of the freeze.
  int stall_left [2];
  int wait_run [2];
  bit prev_frozen [2];
  bit timeout [2];

  hazard_controller #(.LOAD_STALL_CYC(C_A), .MEM_TIMEOUT(T)) dut_a (
    .clk(clk), .reset(reset), .ID_Rs1(id_rs1), .ID_Rs2(id_rs2),
    .ID_UsesRs1(uses1), .ID_UsesRs2(uses2), .EX_Rd(ex_rd), .EX_MemRead(memread),
    .EX_BranchTaken(branch), .MEM_Req(mreq), .MEM_Ready(mready),
    .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .IF_ID_Flush(ifl[0]), .ID_EX_Write(idw[0]),
    .ID_EX_Flush(idf[0]), .EX_MEM_Write(emw[0]), .MEM_WB_Flush(mwf[0]),
    .ctrl_state(cst[0]), .mem_timeout(tmo[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[0]), .flush_events(fe[0]), .wait_cycles(wc[0])
`endif
  );

  hazard_controller #(.LOAD_STALL_CYC(C_B), .MEM_TIMEOUT(T)) dut_b (
    .clk(clk), .reset(reset), .ID_Rs1(id_rs1), .ID_Rs2(id_rs2),
    .ID_UsesRs1(uses1), .ID_UsesRs2(uses2), .EX_Rd(ex_rd), .EX_MemRead(memread),
    .EX_BranchTaken(branch), .MEM_Req(mreq), .MEM_Ready(mready),
    .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .IF_ID_Flush(ifl[1]), .ID_EX_Write(idw[1]),
    .ID_EX_Flush(idf[1]), .EX_MEM_Write(emw[1]), .MEM_WB_Flush(mwf[1]),
    .ctrl_state(cst[1]), .mem_timeout(tmo[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[1]), .flush_events(fe[1]), .wait_cycles(wc[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int stall_len(input int i);
    return (i == 0) ? C_A : C_B;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      stall_left[i]  = 0;
      wait_run[i]    = 0;
      prev_frozen[i] = 1'b0;
      timeout[i]     = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall[i] = '0;
      m_flush[i] = '0;
      m_wait[i]  = '0;
`endif
    end
  endtask

  // One clock: drive at negedge, check before posedge, advance the model after posedge.
  task automatic cycle(input logic r, input logic req, input logic rdy, input logic br,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2);
    logic       lu, ms;
    logic [6:0] exp_v;
    logic [1:0] exp_s;
    @(negedge clk);
    reset = r; mreq = req; mready = rdy; branch = br; memread = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; uses1 = u1; uses2 = u2;
    #1;
    lu = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    ms = req && !rdy;
    for (int i = 0; i < 2; i++) begin
      if (r) exp_v = V_RESET;
      else if (ms) exp_v = V_FREEZE;
      else if (br) exp_v = V_BRANCH;
      else if (stall_left[i] > 0 || lu) exp_v = V_STALL;
      else exp_v = V_IDLE;
      exp_s = r ? 2'd0 : (prev_frozen[i] ? 2'd2 : (stall_left[i] > 0 ? 2'd1 : 2'd0));
      check($sformatf("ctl[%0d]", i),
            32'({pcw[i], ifw[i], ifl[i], idw[i], idf[i], emw[i], mwf[i]}), 32'(exp_v));
      check($sformatf("state[%0d]", i), 32'(cst[i]), 32'(exp_s));
      check($sformatf("timeout[%0d]", i), 32'(tmo[i]), 32'(timeout[i]));
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("stall_cycles[%0d]", i), sc[i], m_stall[i]);
      check($sformatf("flush_events[%0d]", i), fe[i], m_flush[i]);
      check($sformatf("wait_cycles[%0d]", i), wc[i], m_wait[i]);
`endif
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ms) begin
          prev_frozen[i] = 1'b1;
          wait_run[i]++;
          if (wait_run[i] >= T) timeout[i] = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
          m_wait[i]++;
`endif
        end else begin
          prev_frozen[i] = 1'b0;
          wait_run[i]    = 0;
          if (br) begin
            stall_left[i] = 0;
`ifdef HAZARD_PERF_CNT_EN
            m_flush[i]++;
`endif
          end else if (stall_left[i] > 0 || lu) begin
            stall_left[i] = (stall_left[i] > 0) ? stall_left[i] - 1 : stall_len(i) - 1;
`ifdef HAZARD_PERF_CNT_EN
            m_stall[i]++;
`endif
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic lw_use(input logic [4:0] rd);
    cycle(0, 0, 0, 0, 1, rd, rd, 5'd7, 1, 1);
  endtask

  initial begin
    reset = 1'b1; mreq = 0; mready = 0; branch = 0; memread = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; uses1 = 0; uses2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    cycle(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);

    // Load-use on x5, then the x0 variant which must not stall.
    lw_use(5'd5);
    idle(4);
    lw_use(5'd0);
    idle(2);

    // Branch resolves during the stall window.
    lw_use(5'd5);
    cycle(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);

    // Four wait cycles with a taken branch held behind the freeze.
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);

    // Freeze in the middle of a 3-cycle stall.
    lw_use(5'd6);
    cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(4);

    // Watchdog: ten wait cycles, release, flag stays.
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    check("timeout_sticky", 32'(tmo[0]), 32'd1);

    // Reset in the middle of a wait.
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #1;
    check("post_reset_state", 32'(cst[1]), 32'd0);
    check("post_reset_timeout", 32'(tmo[1]), 32'd0);
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
